// File: rtl/ras_ctrl.sv
// Return address stack controller: speculative push/pop from the fetch bundle,
// in-order commit tracking, and a copy FSM that restores the speculative stack
// from the committed stack after a flush.
module ras_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic             fetch_pause,
    input  logic [1:0]       slot_valid,
    input  logic [1:0]       slot_is_call,
    input  logic [1:0]       slot_is_ret,
    input  logic [63:0]      slot_pc,
    output logic             fetch_ready,
    output logic             pred_valid,
    output logic [31:0]      pred_target,
    output logic [PTR_W-1:0] spec_rd_addr,
    input  logic [31:0]      spec_rd_data,
    output logic             spec_we,
    output logic [PTR_W-1:0] spec_waddr,
    output logic [31:0]      spec_wdata,
    input  logic             cmt_valid,
    input  logic             cmt_is_call,
    input  logic             cmt_is_ret,
    input  logic [31:0]      cmt_pc,
    output logic             cmt_we,
    output logic [PTR_W-1:0] cmt_waddr,
    output logic [31:0]      cmt_wdata,
    output logic [PTR_W-1:0] cp_rd_addr,
    input  logic [31:0]      cp_rd_data,
    input  logic             recover,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StCopy} state_e;

    localparam logic [PTR_W:0]   CntMax  = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] IdxLast = PTR_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] spec_top_q, spec_top_d;
    logic [PTR_W-1:0] cmt_top_q, cmt_top_d;
    logic [PTR_W:0]   spec_cnt_q, spec_cnt_d;
    logic [PTR_W:0]   cmt_cnt_q, cmt_cnt_d;
    logic [PTR_W-1:0] copy_idx_q, copy_idx_d;

    logic        accept, act0, act1, act, sel, sel_call, do_call, do_ret, rewind;
    logic [31:0] sel_pc;

    // Pick the oldest slot carrying a call or return; a call flag beats a return flag.
    always_comb begin
        accept   = fetch_valid & ~fetch_pause & (state_q == StIdle) & ~recover;
        act0     = slot_valid[0] & (slot_is_call[0] | slot_is_ret[0]);
        act1     = slot_valid[1] & (slot_is_call[1] | slot_is_ret[1]);
        act      = act0 | act1;
        sel      = ~act0;
        sel_call = slot_is_call[sel];
        sel_pc   = slot_pc[32*sel +: 32];
        do_call  = accept & act & sel_call;
        do_ret   = accept & act & ~sel_call & slot_is_ret[sel];
    end

    // Committed stack update; runs regardless of FSM state.
    always_comb begin
        cmt_we    = cmt_valid & cmt_is_call;
        cmt_waddr = cmt_top_q;
        cmt_wdata = cmt_pc + 32'd8;
        cmt_top_d = cmt_top_q;
        cmt_cnt_d = cmt_cnt_q;
        if (cmt_we) begin
            cmt_top_d = cmt_top_q + 1'b1;
            if (cmt_cnt_q != CntMax) cmt_cnt_d = cmt_cnt_q + 1'b1;
        end else if (cmt_valid && cmt_is_ret && cmt_cnt_q != '0) begin
            cmt_top_d = cmt_top_q - 1'b1;
            cmt_cnt_d = cmt_cnt_q - 1'b1;
        end
    end

    // Speculative push/pop, prediction, and the recovery copy sequencing.
    always_comb begin
        state_d      = state_q;
        spec_top_d   = spec_top_q;
        spec_cnt_d   = spec_cnt_q;
        copy_idx_d   = copy_idx_q;
        spec_we      = 1'b0;
        spec_waddr   = spec_top_q;
        spec_wdata   = sel_pc + 32'd8;
        spec_rd_addr = spec_top_q - 1'b1;
        pred_target  = spec_rd_data;
        pred_valid   = 1'b0;
        cp_rd_addr   = copy_idx_q;
        // A commit landing below the copy cursor must be recopied.
        rewind       = (state_q == StCopy) & cmt_we & (cmt_waddr < copy_idx_q);
        unique case (state_q)
            StIdle: begin
                if (do_call) begin
                    spec_we    = 1'b1;
                    spec_top_d = spec_top_q + 1'b1;
                    if (spec_cnt_q != CntMax) spec_cnt_d = spec_cnt_q + 1'b1;
                end else if (do_ret && spec_cnt_q != '0) begin
                    pred_valid = 1'b1;
                    spec_top_d = spec_top_q - 1'b1;
                    spec_cnt_d = spec_cnt_q - 1'b1;
                end
            end
            StCopy: begin
                spec_we    = 1'b1;
                spec_waddr = copy_idx_q;
                spec_wdata = cp_rd_data;
                if (rewind) begin
                    copy_idx_d = cmt_waddr;
                end else begin
                    copy_idx_d = copy_idx_q + 1'b1;
                    if (copy_idx_q == IdxLast) begin
                        state_d    = StIdle;
                        spec_top_d = cmt_top_d;
                        spec_cnt_d = cmt_cnt_d;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (recover) begin
            state_d    = StCopy;
            copy_idx_d = '0;
        end
    end

    assign busy        = (state_q == StCopy);
    assign fetch_ready = ~busy;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            spec_top_q <= '0;
            cmt_top_q  <= '0;
            spec_cnt_q <= '0;
            cmt_cnt_q  <= '0;
            copy_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            spec_top_q <= spec_top_d;
            cmt_top_q  <= cmt_top_d;
            spec_cnt_q <= spec_cnt_d;
            cmt_cnt_q  <= cmt_cnt_d;
            copy_idx_q <= copy_idx_d;
        end
    end

endmodule
